// File: rtl/if_fetch_pkg.sv
// Shared types, constants and the static branch predictor
// for the instruction fetch unit.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int HOLD_W = 3;
    typedef logic [HOLD_W-1:0] hold_flag_t;
    localparam hold_flag_t HOLD_IF = 3'b010;

    localparam logic [6:0] INST_JAL    = 7'b1101111;
    localparam logic [6:0] INST_TYPE_B = 7'b1100011;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic        prdt;
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    // JAL always taken; conditional branches taken only when backward.
    function automatic pred_t predict(
        input logic [31:0] inst,
        input logic [31:0] addr
    );
        pred_t       p;
        logic [31:0] j_imm;
        logic [31:0] b_imm;
        j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                 inst[20], inst[30:21], 1'b0};
        b_imm = {{19{inst[31]}}, inst[31], inst[7],
                 inst[30:25], inst[11:8], 1'b0};
        p.taken  = 1'b0;
        p.target = addr;
        unique case (1'b1)
            (inst[6:0] == INST_JAL): begin
                p.taken  = 1'b1;
                p.target = addr + j_imm;
            end
            (inst[6:0] == INST_TYPE_B && inst[31]): begin
                p.taken  = 1'b1;
                p.target = addr + b_imm;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO with flush and a combinational head.
// Used for the instruction buffer and the in-flight address queue.
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: pipelined bus reads, instruction buffer,
// static backward-taken prediction and execute-stage redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  hold_flag_t  hold_flag_i,
    input  logic        stall_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        prdt_taken_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef logic [CW-1:0] cnt_t;

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    cnt_t         outstanding;
    cnt_t         outs_nxt;
    cnt_t         drop_cnt;
    cnt_t         drop_nxt;
    cnt_t         fifo_count;
    cnt_t         aq_count;
    logic [31:0]  aq_head;
    logic [CW:0]  in_use;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    pred_t        pred;
    logic         fifo_empty;
    logic         accepted;
    logic         dropped;
    logic         resp;
    logic         issue;
    logic         credit_ok;
    logic         pred_redirect;
    logic         accept_id;

    // A response with no matching queued address is unsolicited.
    assign accepted = ibus_rvalid_i && drop_cnt == '0
                      && aq_count != '0;
    assign dropped  = ibus_rvalid_i && drop_cnt != '0;
    assign resp     = accepted || dropped;

    assign pred          = predict(ibus_rdata_i, aq_head);
    assign pred_redirect = accepted && pred.taken && !jump_flag_i;

    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit_ok = in_use < (CW+1)'(FIFO_DEPTH);

    assign ibus_req_o  = state == RUN && credit_ok
                         && !jump_flag_i && !pred_redirect;
    assign ibus_addr_o = {pc[31:2], 2'b00};
    assign issue       = ibus_req_o && ibus_gnt_i;

    assign accept_id  = !stall_flag_i && hold_flag_i < HOLD_IF;
    assign fifo_empty = fifo_count == '0;

    assign push_entry = '{prdt: pred.taken,
                          addr: aq_head,
                          inst: ibus_rdata_i};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jump_flag_i),
        .push  (accepted),
        .pop   (accept_id && !fifo_empty),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count)
    );

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (jump_flag_i || pred_redirect),
        .push  (issue),
        .pop   (accepted),
        .din   (pc),
        .dout  (aq_head),
        .count (aq_count)
    );

    always_comb begin
        outs_nxt = outstanding + cnt_t'(issue) - cnt_t'(resp);
        drop_nxt = drop_cnt;
        pc_nxt   = pc;
        if (jump_flag_i) begin
            pc_nxt   = jump_addr_i;
            drop_nxt = outstanding - cnt_t'(resp);
        end else if (pred_redirect) begin
            pc_nxt   = pred.target;
            drop_nxt = outstanding - cnt_t'(1);
        end else begin
            if (issue)
                pc_nxt = pc + 32'd4;
            if (dropped)
                drop_nxt = drop_cnt - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= BOOT_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            pc          <= pc_nxt;
            outstanding <= outs_nxt;
            drop_cnt    <= drop_nxt;
            unique case (state)
                BOOT:    state <= RUN;
                default: state <= (drop_nxt != '0) ? DRAIN : RUN;
            endcase
        end
    end

    assign inst_o       = fifo_empty ? INST_NOP  : head.inst;
    assign inst_addr_o  = fifo_empty ? ZERO_WORD : head.addr;
    assign prdt_taken_o = !fifo_empty && head.prdt;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch against a
// program-flow reference model and an in-order bus model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] BOOT  = 32'h0000_0080;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    hold_flag_t  hold_flag_i = '0;
    logic        stall_flag_i = 1'b0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        prdt_taken_o;

    always #5 clk = ~clk;

    if_fetch #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .stall_flag_i  (stall_flag_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .prdt_taken_o  (prdt_taken_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } bus_req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        prdt;
    } exp_t;

    bus_req_t    pending[$];
    exp_t        exp_q[$];
    logic [31:0] spec_word [logic [31:0]];
    logic [31:0] spec_tgt [logic [31:0]];
    logic [31:0] model_pc = BOOT;
    logic [31:0] redirect_addr = BOOT;
    logic        redirect_chk = 1'b0;
    logic        check_lat = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int consumed = 0;
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int first_issue_cyc = -1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_jal(input int off);
        logic [31:0] o;
        o = off;
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] mk_br(input int off,
                                          input logic [2:0] f3);
        logic [31:0] o;
        o = off;
        return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11],
                7'b1100011};
    endfunction

    // Plain addi with a nonzero rd, so never equal to the NOP word.
    function automatic logic [31:0] alu_word(input logic [31:0] a);
        logic [31:0] h;
        logic [4:0]  rd;
        h  = a * 32'h9E37_79B1;
        h  = h ^ (h >> 15);
        rd = (h[4:0] % 5'd31) + 5'd1;
        return {h[31:20], h[19:15], 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (spec_word.exists(a))
            return spec_word[a];
        return alu_word(a);
    endfunction

    task automatic add_taken(input logic [31:0] a,
                             input logic [31:0] w,
                             input logic [31:0] t);
        spec_word[a] = w;
        spec_tgt[a]  = t;
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.addr = model_pc;
            e.inst = mem_word(model_pc);
            e.prdt = spec_tgt.exists(model_pc);
            exp_q.push_back(e);
            model_pc = e.prdt ? spec_tgt[e.addr] : e.addr + 32'd4;
        end
    endtask

    task automatic step(input logic        j,
                        input logic [31:0] ja,
                        input logic        st,
                        input hold_flag_t  hd);
        bus_req_t r;
        @(negedge clk);
        cyc++;
        if (rst)
            pending.delete();
        if (!rst && pending.size() > 0 && pending[0].ready <= cyc) begin
            r = pending.pop_front();
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_word(r.addr);
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
        end
        ibus_gnt_i   = ($urandom_range(99) < gnt_pct);
        jump_flag_i  = j;
        jump_addr_i  = ja;
        stall_flag_i = st;
        hold_flag_i  = hd;
        if (j && !rst) begin
            exp_q.delete();
            model_pc      = ja;
            redirect_chk  = 1'b1;
            redirect_addr = ja;
        end
        refill();
        #1;
        if (!rst) begin
            if (j)
                check("req_during_jump", 32'(ibus_req_o), 32'd0);
            if (ibus_req_o && ibus_gnt_i) begin
                if (redirect_chk) begin
                    check("first_req_after_redirect",
                          ibus_addr_o, redirect_addr);
                    redirect_chk = 1'b0;
                end
                if (first_issue_cyc < 0)
                    first_issue_cyc = cyc;
                r.addr  = ibus_addr_o;
                r.ready = cyc + $urandom_range(lat_max, lat_min);
                pending.push_back(r);
                check("outstanding_bound",
                      32'(pending.size() <= DEPTH), 32'd1);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 32'h0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        check("rst_req", 32'(ibus_req_o), 32'd0);
        check("rst_ibus_addr", ibus_addr_o, BOOT);
        check("rst_inst", inst_o, INST_NOP);
        check("rst_inst_addr", inst_addr_o, 32'h0);
        check("rst_prdt", 32'(prdt_taken_o), 32'd0);
        exp_q.delete();
        model_pc        = BOOT;
        redirect_chk    = 1'b1;
        redirect_addr   = BOOT;
        first_issue_cyc = -1;
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever IF/ID takes an entry.
    initial begin
        logic        v;
        logic        pv;
        logic        pjmp;
        logic        prst;
        logic        phold;
        logic [31:0] pinst;
        logic [31:0] paddr;
        logic        pprdt;
        exp_t        e;
        pv = 1'b0; pjmp = 1'b0; prst = 1'b1; phold = 1'b0;
        pinst = '0; paddr = '0; pprdt = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            v = !(inst_o === INST_NOP && inst_addr_o === 32'h0);
            if (!rst) begin
                if (pjmp && !prst) begin
                    check("empty_after_jump_inst", inst_o, INST_NOP);
                    check("empty_after_jump_addr", inst_addr_o, 32'h0);
                end
                if (phold && pv && !pjmp && !prst) begin
                    check("hold_stable_inst", inst_o, pinst);
                    check("hold_stable_addr", inst_addr_o, paddr);
                    check("hold_stable_prdt", 32'(prdt_taken_o),
                          32'(pprdt));
                end
                if (v && check_lat) begin
                    check("first_inst_latency",
                          32'(cyc - first_issue_cyc), 32'd2);
                    check_lat = 1'b0;
                end
                if (v && !jump_flag_i && !stall_flag_i
                    && hold_flag_i < HOLD_IF) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: got addr %h",
                                 inst_addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_addr", inst_addr_o, e.addr);
                        check("inst", inst_o, e.inst);
                        check("prdt_taken", 32'(prdt_taken_o),
                              32'(e.prdt));
                        consumed++;
                    end
                end
            end
            pv    = v;
            pjmp  = jump_flag_i;
            prst  = rst;
            phold = stall_flag_i || hold_flag_i >= HOLD_IF;
            pinst = inst_o;
            paddr = inst_addr_o;
            pprdt = prdt_taken_o;
        end
    end

    initial begin
        logic [31:0] tgt;
        logic        j;
        logic        st;
        hold_flag_t  hd;
        bit          hit;
        spec_word[32'h0C0] = mk_br(12, 3'b001);
        spec_word[32'h180] = mk_br(8, 3'b001);
        add_taken(32'h090, mk_jal(32), 32'h0B0);
        add_taken(32'h100, mk_br(-16, 3'b000), 32'h0F0);
        add_taken(32'h120, mk_jal(64), 32'h160);
        add_taken(32'h1A0, mk_jal(-256), 32'h0A0);
        add_taken(32'h210, mk_jal(48), 32'h240);
        add_taken(32'h260, mk_br(-96, 3'b100), 32'h200);
        add_taken(32'hFFFF_FFFC, mk_jal(8), 32'h0000_0004);

        do_reset();
        check_lat = 1'b1;
        idle(30);

        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h0, 1'b1, '0);
        idle(10);

        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 1'b0, HOLD_IF);
        idle(10);

        lat_min = 2;
        lat_max = 2;
        idle(6);
        for (int i = 0; i < 20 && pending.size() != 2; i++)
            idle(1);
        step(1'b1, 32'h200, 1'b0, '0);
        idle(15);

        lat_min = 1;
        lat_max = 1;
        step(1'b1, 32'h110, 1'b0, '0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (pending.size() > 0 && pending[0].ready <= cyc + 1
                && pending[0].addr == 32'h120) begin
                step(1'b1, 32'h300, 1'b0, '0);
                hit = 1'b1;
            end else begin
                idle(1);
            end
        end
        check("jal_jump_collision_reached", 32'(hit), 32'd1);
        idle(15);

        gnt_pct = 70;
        lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000)
                do_reset();
            j = $urandom_range(99) < 3;
            case ($urandom_range(5))
                0: tgt = 32'h080;
                1: tgt = 32'h110;
                2: tgt = 32'h1F8;
                3: tgt = 32'h200;
                4: tgt = 32'hFFFF_FFF4;
                default: tgt = {22'h0, 8'($urandom_range(255)), 2'b00};
            endcase
            st = $urandom_range(99) < 15;
            hd = ($urandom_range(99) < 15)
                 ? hold_flag_t'($urandom_range(4)) : '0;
            step(j, tgt, st, hd);
        end
        idle(20);
        check("progress", 32'(consumed >= 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
